// File: rtl/clock_set_controller_if.sv
// Button inputs, live time and edit/load outputs shared between digital_clock and its time-set controller.
interface clock_set_controller_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_dec;
    logic [5:0] cur_seconds;
    logic [5:0] cur_minutes;
    logic [4:0] cur_hours;
    logic       run_enable;
    logic [1:0] edit_field;
    logic       load_valid;
    logic [5:0] load_seconds;
    logic [5:0] load_minutes;
    logic [4:0] load_hours;
    logic       blink;

    modport master (
        output btn_mode, btn_inc, btn_dec, cur_seconds, cur_minutes, cur_hours,
        input  run_enable, edit_field, load_valid, load_seconds, load_minutes, load_hours, blink
    );

    modport slave (
        input  btn_mode, btn_inc, btn_dec, cur_seconds, cur_minutes, cur_hours,
        output run_enable, edit_field, load_valid, load_seconds, load_minutes, load_hours, blink
    );
endinterface

// File: rtl/clock_set_controller.sv
// Time-set controller: conditions the three push-buttons, then edits hours/minutes/seconds in
// shadow registers and writes them back to digital_clock with a one-cycle load strobe.
module ButtonConditioner #(
    parameter int unsigned DEBOUNCE_CYCLES     = 1_000_000,
    parameter int unsigned REPEAT_DELAY_CYCLES = 25_000_000,
    parameter int unsigned REPEAT_RATE_CYCLES  = 5_000_000,
    parameter bit          REPEAT_EN           = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_press
);
    localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned REP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                                      REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_levelPrev;
    logic [DB_W-1:0]  r_dbCnt;
    logic [REP_W-1:0] r_repCnt;
    logic             r_repeating;
    logic             r_press;
    logic             w_rise;
    logic             w_repFire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // The level is only accepted after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level <= 1'b0;
            r_dbCnt <= '0;
        end else if (r_sync2 == r_level) begin
            r_dbCnt <= '0;
        end else if (r_dbCnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            r_level <= r_sync2;
            r_dbCnt <= '0;
        end else begin
            r_dbCnt <= r_dbCnt + 1'b1;
        end
    end

    assign w_rise    = r_level & ~r_levelPrev;
    assign w_repFire = REPEAT_EN && r_level &&
                       (r_repCnt == (r_repeating ? REP_W'(REPEAT_RATE_CYCLES) : REP_W'(REPEAT_DELAY_CYCLES)));

    // r_repCnt counts cycles since the last pulse; the first gap is the delay, later ones the rate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_levelPrev <= 1'b0;
            r_repCnt    <= '0;
            r_repeating <= 1'b0;
            r_press     <= 1'b0;
        end else begin
            r_levelPrev <= r_level;
            r_press     <= w_rise | w_repFire;
            if (!REPEAT_EN || !r_level) begin
                r_repCnt    <= '0;
                r_repeating <= 1'b0;
            end else if (w_rise) begin
                r_repCnt    <= REP_W'(1);
                r_repeating <= 1'b0;
            end else if (w_repFire) begin
                r_repCnt    <= REP_W'(1);
                r_repeating <= 1'b1;
            end else begin
                r_repCnt <= r_repCnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;
endmodule

module clock_set_controller #(
    parameter int unsigned CLOCK_FREQ          = 50_000_000,
    parameter int unsigned DEBOUNCE_CYCLES     = 1_000_000,
    parameter int unsigned REPEAT_DELAY_CYCLES = 25_000_000,
    parameter int unsigned REPEAT_RATE_CYCLES  = 5_000_000,
    parameter int unsigned BLINK_HALF_CYCLES   = 12_500_000
) (
    input logic                   clk,
    input logic                   reset,
    clock_set_controller_if.slave bus
);
    localparam int unsigned BLINK_W = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;

    if (CLOCK_FREQ == 0) begin : g_badClockFreq
        $error("CLOCK_FREQ must be non-zero");
    end

    typedef enum logic [2:0] {RUN, SET_H, SET_M, SET_S, COMMIT} stateType;

    stateType           r_state;
    stateType           w_nextState;
    logic [5:0]         r_loadSeconds;
    logic [5:0]         r_loadMinutes;
    logic [4:0]         r_loadHours;
    logic               r_blink;
    logic [BLINK_W-1:0] r_blinkCnt;
    logic               w_modePress;
    logic               w_incPress;
    logic               w_decPress;
    logic               w_inSet;
    logic               w_nextInSet;
    logic               w_edit;
    logic               w_runEnable;
    logic [1:0]         w_editField;
    logic               w_loadValid;

    function automatic logic [5:0] stepSixty(input logic [5:0] value, input logic up);
        if (up) stepSixty = (value == 6'd59) ? 6'd0 : value + 6'd1;
        else    stepSixty = (value == 6'd0) ? 6'd59 : value - 6'd1;
    endfunction

    function automatic logic [4:0] stepHours(input logic [4:0] value, input logic up);
        if (up) stepHours = (value == 5'd23) ? 5'd0 : value + 5'd1;
        else    stepHours = (value == 5'd0) ? 5'd23 : value - 5'd1;
    endfunction

    ButtonConditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
        .REPEAT_RATE_CYCLES(REPEAT_RATE_CYCLES), .REPEAT_EN(1'b0)
    ) u_modeButton (.clk(clk), .reset(reset), .i_raw(bus.btn_mode), .o_press(w_modePress));

    ButtonConditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
        .REPEAT_RATE_CYCLES(REPEAT_RATE_CYCLES), .REPEAT_EN(1'b1)
    ) u_incButton (.clk(clk), .reset(reset), .i_raw(bus.btn_inc), .o_press(w_incPress));

    ButtonConditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
        .REPEAT_RATE_CYCLES(REPEAT_RATE_CYCLES), .REPEAT_EN(1'b1)
    ) u_decButton (.clk(clk), .reset(reset), .i_raw(bus.btn_dec), .o_press(w_decPress));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= RUN;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            RUN:     if (w_modePress) w_nextState = SET_H;
            SET_H:   if (w_modePress) w_nextState = SET_M;
            SET_M:   if (w_modePress) w_nextState = SET_S;
            SET_S:   if (w_modePress) w_nextState = COMMIT;
            COMMIT:  w_nextState = RUN;
            default: w_nextState = RUN;
        endcase
    end

    always_comb begin
        w_runEnable = 1'b0;
        w_editField = 2'd0;
        w_loadValid = 1'b0;
        case (r_state)
            RUN:     w_runEnable = 1'b1;
            SET_H:   w_editField = 2'd1;
            SET_M:   w_editField = 2'd2;
            SET_S:   w_editField = 2'd3;
            COMMIT: begin
                w_runEnable = 1'b1;
                w_loadValid = 1'b1;
            end
            default: w_runEnable = 1'b1;
        endcase
    end

    // Mode outranks inc/dec, and opposing presses in the same cycle cancel out.
    assign w_inSet     = (r_state == SET_H) || (r_state == SET_M) || (r_state == SET_S);
    assign w_nextInSet = (w_nextState == SET_H) || (w_nextState == SET_M) || (w_nextState == SET_S);
    assign w_edit      = w_inSet && !w_modePress && (w_incPress ^ w_decPress);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_loadSeconds <= '0;
            r_loadMinutes <= '0;
            r_loadHours   <= '0;
        end else if (r_state == RUN && w_modePress) begin
            r_loadSeconds <= bus.cur_seconds;
            r_loadMinutes <= bus.cur_minutes;
            r_loadHours   <= bus.cur_hours;
        end else if (w_edit) begin
            case (r_state)
                SET_H:   r_loadHours   <= stepHours(r_loadHours, w_incPress);
                SET_M:   r_loadMinutes <= stepSixty(r_loadMinutes, w_incPress);
                SET_S:   r_loadSeconds <= stepSixty(r_loadSeconds, w_incPress);
                default: ;
            endcase
        end
    end

    // Blink restarts lit on every field entry and accepted edit so the new value is visible at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink    <= 1'b0;
            r_blinkCnt <= '0;
        end else if (!w_nextInSet) begin
            r_blink    <= 1'b0;
            r_blinkCnt <= '0;
        end else if ((w_nextState != r_state) || w_edit) begin
            r_blink    <= 1'b1;
            r_blinkCnt <= '0;
        end else if (r_blinkCnt == BLINK_W'(BLINK_HALF_CYCLES - 1)) begin
            r_blink    <= ~r_blink;
            r_blinkCnt <= '0;
        end else begin
            r_blinkCnt <= r_blinkCnt + 1'b1;
        end
    end

    assign bus.run_enable   = w_runEnable;
    assign bus.edit_field   = w_editField;
    assign bus.load_valid   = w_loadValid;
    assign bus.load_seconds = r_loadSeconds;
    assign bus.load_minutes = r_loadMinutes;
    assign bus.load_hours   = r_loadHours;
    assign bus.blink        = r_blink;
endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with short debounce/repeat/blink timing; every expected
// value below is worked out by hand from the press timing (raw edge -> state change 8 edges later).
module tb_clock_set_controller;
    logic clk = 1'b0;
    logic reset;
    int   checkCount = 0;
    int   errorCount = 0;
    int   loadPulseCount = 0;
    logic [5:0] seenSeconds[$];
    logic [5:0] prevSeconds;
    logic [5:0] expRepeat [5];

    clock_set_controller_if bus();

    clock_set_controller #(
        .CLOCK_FREQ(50_000_000),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY_CYCLES(20),
        .REPEAT_RATE_CYCLES(5),
        .BLINK_HALF_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.load_valid === 1'b1) loadPulseCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            errorCount++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkEdit(input string tag, input int field, input int hours, input int minutes, input int seconds);
        checkOutput({tag, ".edit_field"}, bus.edit_field, field);
        checkOutput({tag, ".run_enable"}, bus.run_enable, (field == 0) ? 1 : 0);
        checkOutput({tag, ".hours"}, bus.load_hours, hours);
        checkOutput({tag, ".minutes"}, bus.load_minutes, minutes);
        checkOutput({tag, ".seconds"}, bus.load_seconds, seconds);
    endtask

    // Idles 8 cycles so the previous press has fully released, then holds the raw buttons for 8
    // cycles; it returns on the falling edge right after the FSM has acted on the press.
    task automatic applyStimulus(input logic mode, input logic inc, input logic dec);
        repeat (8) @(negedge clk);
        bus.btn_mode = mode;
        bus.btn_inc  = inc;
        bus.btn_dec  = dec;
        repeat (8) @(negedge clk);
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.btn_dec  = 1'b0;
    endtask

    task automatic recordSeconds();
        @(negedge clk);
        if (bus.load_seconds !== prevSeconds) begin
            seenSeconds.push_back(bus.load_seconds);
            prevSeconds = bus.load_seconds;
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus.btn_mode    = 1'b0;
        bus.btn_inc     = 1'b0;
        bus.btn_dec     = 1'b0;
        bus.cur_hours   = 5'd0;
        bus.cur_minutes = 6'd0;
        bus.cur_seconds = 6'd0;
        expRepeat       = '{6'd59, 6'd0, 6'd1, 6'd2, 6'd3};
        repeat (3) @(negedge clk);
        checkEdit("reset", 0, 0, 0, 0);
        checkOutput("reset.load_valid", bus.load_valid, 0);
        checkOutput("reset.blink", bus.blink, 0);
        reset = 1'b0;

        $display("[TB] full edit sequence from 05:30:15");
        bus.cur_hours = 5'd5; bus.cur_minutes = 6'd30; bus.cur_seconds = 6'd15;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkEdit("enterH", 1, 5, 30, 15);
        checkOutput("enterH.blink", bus.blink, 1);
        repeat (8) @(negedge clk);
        checkOutput("blinkFirstToggle", bus.blink, 0);
        repeat (8) @(negedge clk);
        checkOutput("blinkSecondToggle", bus.blink, 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkEdit("incH1", 1, 6, 30, 15);
        checkOutput("incH1.blink", bus.blink, 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkEdit("incH2", 1, 7, 30, 15);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkEdit("enterM", 2, 7, 30, 15);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkEdit("decM", 2, 7, 29, 15);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkEdit("enterS", 3, 7, 29, 15);
        checkOutput("preCommit.loadPulses", loadPulseCount, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("commit.load_valid", bus.load_valid, 1);
        checkOutput("commit.blink", bus.blink, 0);
        checkEdit("commit", 0, 7, 29, 15);
        @(negedge clk);
        checkOutput("afterCommit.load_valid", bus.load_valid, 0);
        checkEdit("afterCommit", 0, 7, 29, 15);
        repeat (4) @(negedge clk);
        checkOutput("commit.loadPulses", loadPulseCount, 1);

        $display("[TB] wrap-around, bounce rejection and auto-repeat from 00:10:59");
        bus.cur_hours = 5'd0; bus.cur_minutes = 6'd10; bus.cur_seconds = 6'd59;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkEdit("capture2", 1, 0, 10, 59);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkEdit("hoursDecWrap", 1, 23, 10, 59);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkEdit("hoursIncWrap", 1, 0, 10, 59);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkEdit("enterM2", 2, 0, 10, 59);
        repeat (8) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            bus.btn_inc = ((k % 2) == 0);
            repeat (2) @(negedge clk);
        end
        checkEdit("bounceOnly", 2, 0, 10, 59);
        bus.btn_inc = 1'b1;
        repeat (8) @(negedge clk);
        bus.btn_inc = 1'b0;
        repeat (8) @(negedge clk);
        checkEdit("bounceThenHold", 2, 0, 11, 59);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkEdit("enterS2", 3, 0, 11, 59);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkEdit("secondsIncWrap", 3, 0, 11, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkEdit("seconds58", 3, 0, 11, 58);

        // 38 raw cycles: initial pulse plus four repeats land before the released level debounces low.
        repeat (8) @(negedge clk);
        seenSeconds.delete();
        prevSeconds = bus.load_seconds;
        bus.btn_inc = 1'b1;
        for (int k = 0; k < 38; k++) recordSeconds();
        bus.btn_inc = 1'b0;
        for (int k = 0; k < 40; k++) recordSeconds();
        checkOutput("repeat.count", seenSeconds.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < seenSeconds.size()) checkOutput($sformatf("repeat.value%0d", k), seenSeconds[k], expRepeat[k]);
        end
        checkEdit("repeatDone", 3, 0, 11, 3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("commit2.load_valid", bus.load_valid, 1);
        checkEdit("commit2", 0, 0, 11, 3);
        repeat (4) @(negedge clk);
        checkOutput("commit2.loadPulses", loadPulseCount, 2);

        $display("[TB] simultaneous presses and reset mid-edit from 14:00:00");
        bus.cur_hours = 5'd14; bus.cur_minutes = 6'd0; bus.cur_seconds = 6'd0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkEdit("capture3", 1, 14, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkEdit("modeWithInc", 2, 14, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkEdit("minutesDecWrap", 2, 14, 59, 0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkEdit("incWithDec", 2, 14, 59, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checkEdit("midReset", 0, 0, 0, 0);
        checkOutput("midReset.load_valid", bus.load_valid, 0);
        checkOutput("midReset.blink", bus.blink, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("midReset.loadPulses", loadPulseCount, 2);
        bus.cur_hours = 5'd21; bus.cur_minutes = 6'd45; bus.cur_seconds = 6'd33;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkEdit("recapture", 1, 21, 45, 33);
        checkOutput("recapture.blink", bus.blink, 1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
